// File: rtl/jt12_wrq_pkg.sv
// Shared definitions for the jt12_wr_queue register-write sequencer:
// FSM state codes, queued entry layout and the YM2612 busy-bit index.
package jt12_wrq_pkg;

    localparam int ENTRY_W     = 17;
    localparam int DATA_LSB    = 0;
    localparam int REG_LSB     = 8;
    localparam int BANK_BIT    = 16;
    localparam int YM_BUSY_BIT = 7;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_A_WR  = 3'd1;
    localparam logic [2:0] ST_A_GAP = 3'd2;
    localparam logic [2:0] ST_D_WR  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_S_RD  = 3'd5;
    localparam logic [2:0] ST_S_CHK = 3'd6;

    typedef struct packed {
        logic       bank;
        logic [7:0] addr;
        logic [7:0] data;
    } wrq_entry_t;

    function automatic wrq_entry_t wrq_pack(input logic bank, input logic [7:0] addr,
                                            input logic [7:0] data);
        logic [ENTRY_W-1:0] raw;
        raw                  = {ENTRY_W{1'b0}};
        raw[BANK_BIT]        = bank;
        raw[REG_LSB +: 8]    = addr;
        raw[DATA_LSB +: 8]   = data;
        return wrq_entry_t'(raw);
    endfunction

endpackage

// File: rtl/jt12_wr_queue_if.sv
// Host write-request channel of jt12_wr_queue: valid/ready plus the
// {bank, register, data} payload.
interface jt12_wr_queue_if;

    logic       wr_valid;
    logic       wr_ready;
    logic       wr_bank;
    logic [7:0] wr_reg;
    logic [7:0] wr_data;

    modport master (output wr_valid, output wr_bank, output wr_reg, output wr_data,
                    input  wr_ready);

    modport slave  (input  wr_valid, input  wr_bank, input  wr_reg, input  wr_data,
                    output wr_ready);

endinterface

// File: rtl/jt12_wrq_fifo.sv
// Request FIFO for jt12_wr_queue: DEPTH x 17-bit storage with wrap-bit
// pointers; flush clears both pointers and beats a simultaneous push.
module jt12_wrq_fifo
    import jt12_wrq_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        push_i,
    input  wrq_entry_t  din_i,
    input  logic        pop_i,
    output wrq_entry_t  dout_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [AW:0] level_o
);

    wrq_entry_t  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        push_s;
    logic        pop_s;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign push_s  = push_i && !full_o && !flush_i;
    assign pop_s   = pop_i && !empty_o;

    // Pointer next-state: flush clears, otherwise advance on push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = {(AW+1){1'b0}};
            rd_ptr_d = {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/jt12_wr_queue.sv
// YM2612 register-write sequencer: queues {bank, reg, data} requests and
// replays them as paced address/data bus writes. Optional macro
// JT12_WRQ_BUSYPOLL_EN replaces the fixed post-write wait with busy polling.
module jt12_wr_queue
    import jt12_wrq_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int STB      = 2,
    parameter int GAP      = 2,
    parameter int WAIT_CYC = 192,
    parameter int POLL_MAX = 255
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cen_i,
    input  logic                     flush_i,
    jt12_wr_queue_if.slave           wr,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     idle_o,
    output logic                     timeout_o,
    output logic [1:0]               ym_addr_o,
    output logic [7:0]               ym_din_o,
    output logic                     ym_cs_n_o,
    output logic                     ym_wr_n_o,
    input  logic [7:0]               ym_dout_i
);

    localparam int MAX_SG = (STB > GAP) ? STB : GAP;
    localparam int MAX_C  = (MAX_SG > WAIT_CYC) ? MAX_SG : WAIT_CYC;
    localparam int CNT_W  = $clog2(MAX_C) + 1;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cs_n_q, cs_n_d;
    logic             wr_n_q, wr_n_d;
    logic [1:0]       addr_q, addr_d;
    logic [7:0]       din_q, din_d;
    logic [7:0]       data_q, data_d;
    logic             bank_q, bank_d;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic             cnt_zero_s;
    wrq_entry_t       head_s;
    wrq_entry_t       push_ent_s;

`ifdef JT12_WRQ_BUSYPOLL_EN
    localparam int PW = $clog2(POLL_MAX + 1);
    logic          busy_q, busy_d;
    logic [PW-1:0] poll_q, poll_d;
    logic          timeout_q, timeout_d;
    logic [6:0]    dout_unused_s;
    assign dout_unused_s = ym_dout_i[6:0];
    assign timeout_o     = timeout_q;
`else
    logic          dout_unused_s;
    assign dout_unused_s = ^ym_dout_i;
    assign timeout_o     = 1'b0;
`endif

    assign push_ent_s = wrq_pack(wr.wr_bank, wr.wr_reg, wr.wr_data);

    jt12_wrq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .push_i  (wr.wr_valid),
        .din_i   (push_ent_s),
        .pop_i   (pop_s),
        .dout_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .level_o (level_o)
    );

    assign wr.wr_ready = !full_s;
    assign idle_o      = empty_s && (state_q == ST_IDLE);
    assign cnt_zero_s  = (cnt_q == {CNT_W{1'b0}});
    assign ym_addr_o   = addr_q;
    assign ym_din_o    = din_q;
    assign ym_cs_n_o   = cs_n_q;
    assign ym_wr_n_o   = wr_n_q;

    // Sequencer next-state: every stage counter loads N-1 and leaves at 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cs_n_d  = cs_n_q;
        wr_n_d  = wr_n_q;
        addr_d  = addr_q;
        din_d   = din_q;
        data_d  = data_q;
        bank_d  = bank_q;
        pop_s   = 1'b0;
`ifdef JT12_WRQ_BUSYPOLL_EN
        busy_d    = busy_q;
        poll_d    = poll_q;
        timeout_d = timeout_q;
`endif
        if (cen_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty_s) begin
                        pop_s   = 1'b1;
                        state_d = ST_A_WR;
                        cnt_d   = CNT_W'(STB - 1);
                        cs_n_d  = 1'b0;
                        wr_n_d  = 1'b0;
                        addr_d  = {head_s.bank, 1'b0};
                        din_d   = head_s.addr;
                        data_d  = head_s.data;
                        bank_d  = head_s.bank;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_A_WR: begin
                    if (cnt_zero_s) begin
                        state_d = ST_A_GAP;
                        cnt_d   = CNT_W'(GAP - 1);
                        cs_n_d  = 1'b1;
                        wr_n_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_A_GAP: begin
                    if (cnt_zero_s) begin
                        state_d = ST_D_WR;
                        cnt_d   = CNT_W'(STB - 1);
                        cs_n_d  = 1'b0;
                        wr_n_d  = 1'b0;
                        addr_d  = {bank_q, 1'b1};
                        din_d   = data_q;
                    end else begin
                        cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_D_WR: begin
                    if (cnt_zero_s) begin
                        cs_n_d = 1'b1;
                        wr_n_d = 1'b1;
`ifdef JT12_WRQ_BUSYPOLL_EN
                        // A release cycle precedes the first status read.
                        state_d = ST_S_CHK;
                        busy_d  = 1'b1;
                        poll_d  = {PW{1'b0}};
`else
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYC - 1);
`endif
                    end else begin
                        cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
`ifdef JT12_WRQ_BUSYPOLL_EN
                ST_S_RD: begin
                    if (cnt_zero_s) begin
                        state_d = ST_S_CHK;
                        cs_n_d  = 1'b1;
                        busy_d  = ym_dout_i[YM_BUSY_BIT];
                        if (ym_dout_i[YM_BUSY_BIT]) begin
                            poll_d = poll_q + {{(PW-1){1'b0}}, 1'b1};
                        end else begin
                            poll_d = poll_q;
                        end
                    end else begin
                        cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_S_CHK: begin
                    if (!busy_q) begin
                        state_d = ST_IDLE;
                    end else if (poll_q == PW'(POLL_MAX)) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = ST_S_RD;
                        cnt_d   = CNT_W'(STB - 1);
                        cs_n_d  = 1'b0;
                        wr_n_d  = 1'b1;
                        addr_d  = 2'd0;
                    end
                end
`else
                ST_WAIT: begin
                    if (cnt_zero_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    cs_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                end
            endcase
        end else begin
            state_d = state_q;
        end
`ifdef JT12_WRQ_BUSYPOLL_EN
        if (flush_i) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_d;
        end
`endif
    end

    // Sequencer and bus-driver registers; reset drops any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            addr_q  <= 2'd0;
            din_q   <= 8'd0;
            data_q  <= 8'd0;
            bank_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_n_q  <= cs_n_d;
            wr_n_q  <= wr_n_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            data_q  <= data_d;
            bank_q  <= bank_d;
        end
    end

`ifdef JT12_WRQ_BUSYPOLL_EN
    // Busy-poll bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            poll_q    <= {PW{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            poll_q    <= poll_d;
            timeout_q <= timeout_d;
        end
    end
`endif

endmodule

// File: tb/tb_jt12_wr_queue.sv
// Randomized bench for jt12_wr_queue (default build, fixed post-write wait)
// against a queue-plus-timeline reference model.
module tb_jt12_wr_queue;

    localparam int DEPTH    = 16;
    localparam int STB      = 2;
    localparam int GAP      = 2;
    localparam int WAIT_CYC = 192;
    localparam int TOTAL    = 2 * STB + GAP + WAIT_CYC;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       cen     = 1'b0;
    logic       flush   = 1'b0;
    logic [7:0] ym_dout = 8'd0;
    logic [4:0] level;
    logic       idle;
    logic       timeout;
    logic [1:0] ym_addr;
    logic [7:0] ym_din;
    logic       ym_cs_n;
    logic       ym_wr_n;

    jt12_wr_queue_if wr_if ();

    jt12_wr_queue #(.DEPTH(DEPTH), .STB(STB), .GAP(GAP), .WAIT_CYC(WAIT_CYC), .POLL_MAX(255)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen_i     (cen),
        .flush_i   (flush),
        .wr        (wr_if),
        .level_o   (level),
        .idle_o    (idle),
        .timeout_o (timeout),
        .ym_addr_o (ym_addr),
        .ym_din_o  (ym_din),
        .ym_cs_n_o (ym_cs_n),
        .ym_wr_n_o (ym_wr_n),
        .ym_dout_i (ym_dout)
    );

    always #5 clk = ~clk;

    // Reference model: queued requests plus the cen-tick position inside the
    // transaction currently on the bus.
    typedef struct {
        bit       bank;
        bit [7:0] ra;
        bit [7:0] d;
    } ent_t;

    ent_t m_q[$];
    ent_t m_cur;
    bit   m_active = 1'b0;
    int   m_pos    = 0;
    int   n_cmp    = 0;
    int   n_err    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_idle();
        return !m_active && (m_q.size() == 0);
    endfunction

    task automatic check_outputs();
        bit sa;
        bit sd;
        sa = m_active && (m_pos < STB);
        sd = m_active && (m_pos >= STB + GAP) && (m_pos < 2 * STB + GAP);
        check_eq("cs_n", 32'(ym_cs_n), 32'(!(sa || sd)));
        check_eq("wr_n", 32'(ym_wr_n), 32'(!(sa || sd)));
        if (sa) begin
            check_eq("addr_a", 32'(ym_addr), 32'({m_cur.bank, 1'b0}));
            check_eq("din_a", 32'(ym_din), 32'(m_cur.ra));
        end else if (sd) begin
            check_eq("addr_d", 32'(ym_addr), 32'({m_cur.bank, 1'b1}));
            check_eq("din_d", 32'(ym_din), 32'(m_cur.d));
        end
        check_eq("level", 32'(level), 32'(m_q.size()));
        check_eq("wr_ready", 32'(wr_if.wr_ready), 32'(m_q.size() < DEPTH));
        check_eq("idle", 32'(idle), 32'(m_idle()));
        check_eq("timeout", 32'(timeout), 32'd0);
    endtask

    // One clock: advance the model with the inputs now applied, then check.
    task automatic step();
        int sz;
        bit do_push;
        sz      = m_q.size();
        do_push = wr_if.wr_valid && (sz < DEPTH) && !flush;
        if (cen) begin
            if (m_active) begin
                m_pos++;
                if (m_pos == TOTAL) m_active = 1'b0;
            end else if (sz > 0) begin
                m_cur    = m_q.pop_front();
                m_active = 1'b1;
                m_pos    = 0;
            end
        end
        if (flush) m_q.delete();
        else if (do_push) m_q.push_back('{wr_if.wr_bank, wr_if.wr_reg, wr_if.wr_data});
        @(posedge clk);
        #1;
        ym_dout = 8'($urandom);
        check_outputs();
    endtask

    task automatic set_req(input bit v);
        wr_if.wr_valid = v;
        wr_if.wr_bank  = 1'($urandom);
        wr_if.wr_reg   = 8'($urandom);
        wr_if.wr_data  = 8'($urandom);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && !m_idle(); i++) step();
        check_eq("drain_idle", 32'(idle), 32'd1);
    endtask

    initial begin
        set_req(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cs_n", 32'(ym_cs_n), 32'd1);
        check_eq("rst_wr_n", 32'(ym_wr_n), 32'd1);
        check_eq("rst_addr", 32'(ym_addr), 32'd0);
        check_eq("rst_din", 32'(ym_din), 32'd0);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Single write {0, 0x28, 0xF0} at full rate.
        cen = 1'b1;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_bank  = 1'b0;
        wr_if.wr_reg   = 8'h28;
        wr_if.wr_data  = 8'hF0;
        step();
        set_req(1'b0);
        for (int i = 0; i < TOTAL + 20; i++) step();
        check_eq("single_idle", 32'(idle), 32'd1);

        // Asynchronous reset in the middle of an address strobe.
        wr_if.wr_valid = 1'b1;
        wr_if.wr_bank  = 1'b1;
        step();
        set_req(1'b0);
        for (int i = 0; i < 10 && !(m_active && m_pos < STB); i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_cs_n", 32'(ym_cs_n), 32'd1);
        check_eq("rst_mid_wr_n", 32'(ym_wr_n), 32'd1);
        check_eq("rst_mid_level", 32'(level), 32'd0);
        m_q.delete();
        m_active = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) step();

        // Fill to full with cen held low, offer a 17th entry, then drain.
        cen = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_req(1'b1);
            step();
        end
        check_eq("full_ready", 32'(wr_if.wr_ready), 32'd0);
        check_eq("full_level", 32'(level), 32'd16);
        set_req(1'b1);
        step();
        check_eq("full_hold_level", 32'(level), 32'd16);
        set_req(1'b0);
        cen = 1'b1;
        drain(DEPTH * (TOTAL + 1) + 50);

        // cen every 6th clock; pushes land on non-cen clocks.
        for (int i = 0; i < 2500; i++) begin
            cen = (i % 6 == 0);
            set_req(i == 3 || i == 700 || i == 1000);
            step();
        end
        set_req(1'b0);
        for (int i = 0; i < 6000 && !m_idle(); i++) begin
            cen = (i % 6 == 0);
            step();
        end
        check_eq("cen6_idle", 32'(idle), 32'd1);

        // Flush during the data strobe with five entries still queued.
        cen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_req(1'b1);
            step();
        end
        set_req(1'b0);
        cen = 1'b1;
        for (int i = 0; i < 20 && !(m_active && m_pos >= STB + GAP); i++) step();
        check_eq("pre_flush_level", 32'(level), 32'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("flush_level", 32'(level), 32'd0);
        drain(TOTAL + 20);
        flush = 1'b1;
        set_req(1'b1);
        step();
        flush = 1'b0;
        set_req(1'b0);
        check_eq("flush_push_level", 32'(level), 32'd0);

        // Randomized traffic: sparse cen, pushes, occasional flush.
        for (int i = 0; i < 6000; i++) begin
            cen   = ($urandom % 4) != 0;
            flush = ($urandom % 800) == 0;
            set_req(($urandom % 30) == 0);
            step();
        end
        flush = 1'b0;
        set_req(1'b0);
        cen = 1'b1;
        drain(DEPTH * (TOTAL + 1) + 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
